// File: rtl/flex_timer_pkg.sv
// flex_timer_pkg: shared types and constants for the flex_timer slice.
//   mode_t  : counter behaviour on reaching the terminal value
//   DIR_*   : encoding of the up_down_i input
`timescale 1ns/1ps
package flex_timer_pkg;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/flex_prescaler.sv
// flex_prescaler: divides enabled cycles into ticks.
//   clk, n_rst       : clock, asynchronous active-low reset
//   enable_i         : advance the prescaler this cycle
//   clear_i          : synchronous return to phase 0
//   prescale_value_i : tick every prescale_value_i enabled cycles (0 and 1 = every cycle)
//   tick_o           : combinational tick, valid in the cycle it is consumed
`timescale 1ns/1ps
module flex_prescaler #(
    parameter int unsigned PRESCALE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [PRESCALE_BITS-1:0] prescale_value_i,
    output logic                     tick_o
);

    logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
    logic                     at_end;

    assign at_end = (prescale_value_i <= PRESCALE_BITS'(1)) ||
                    (pcnt_q == prescale_value_i - PRESCALE_BITS'(1));
    assign tick_o = enable_i & at_end;

    // A disabled cycle holds the phase, so a halt never loses prescaler progress.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clear_i) begin
            pcnt_d = '0;
        end else if (tick_o) begin
            pcnt_d = '0;
        end else if (enable_i) begin
            pcnt_d = pcnt_q + PRESCALE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/flex_timer.sv
// flex_timer: up/down timer-counter with prescaler, wrap/one-shot modes and load.
//   clk, n_rst        : clock, asynchronous active-low reset
//   count_enable_i    : run enable;  halt_i freezes everything, overriding it
//   clear_i / load_i  : synchronous clear (highest priority) / load of load_value_i
//   up_down_i, mode_i : direction (DIR_UP/DIR_DOWN), MODE_WRAP or MODE_ONESHOT
//   rollover_value_i  : period R;  prescale_value_i : tick divider
//   count_out_o       : current count
//   rollover_flag_o   : registered count == terminal (R up, 0 down)
//   term_pulse_o      : one-cycle pulse on tick-driven arrival at terminal
//   done_o            : sticky one-shot completion
`timescale 1ns/1ps
module flex_timer
    import flex_timer_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS  = 4,
    parameter int unsigned PRESCALE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     count_enable_i,
    input  logic                     halt_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [NUM_CNT_BITS-1:0]  load_value_i,
    input  logic                     up_down_i,
    input  logic                     mode_i,
    input  logic [NUM_CNT_BITS-1:0]  rollover_value_i,
    input  logic [PRESCALE_BITS-1:0] prescale_value_i,
    output logic [NUM_CNT_BITS-1:0]  count_out_o,
    output logic                     rollover_flag_o,
    output logic                     term_pulse_o,
    output logic                     done_o
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    rf_q, rf_d;
    logic                    tp_q, tp_d;
    logic                    done_q, done_d;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic [NUM_CNT_BITS-1:0] stepped;
    logic                    run_en;
    logic                    tick;
    logic                    arrive;

    // done_q gates the prescaler so a finished one-shot stops ticking until clear/load.
    assign run_en = count_enable_i & ~halt_i & ~done_q;

    flex_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk              (clk),
        .n_rst            (n_rst),
        .enable_i         (run_en),
        .clear_i          (clear_i | load_i),
        .prescale_value_i (prescale_value_i),
        .tick_o           (tick)
    );

    assign terminal = (up_down_i == DIR_UP) ? rollover_value_i : '0;

    // Up wraps R -> 1, down wraps 0 -> R-1: both directions give a period of R ticks.
    always_comb begin
        stepped = count_q;
        if (up_down_i == DIR_DOWN) begin
            stepped = (count_q == '0) ? rollover_value_i - NUM_CNT_BITS'(1)
                                      : count_q - NUM_CNT_BITS'(1);
        end else begin
            stepped = (count_q == rollover_value_i) ? NUM_CNT_BITS'(1)
                                                    : count_q + NUM_CNT_BITS'(1);
        end
    end

    assign arrive = (stepped == terminal);

    // Priority: clear > load > halt > tick > hold.
    always_comb begin
        count_d = count_q;
        rf_d    = rf_q;
        tp_d    = 1'b0;
        done_d  = done_q;
        if (clear_i) begin
            count_d = '0;
            rf_d    = 1'b0;
            done_d  = 1'b0;
        end else if (load_i) begin
            count_d = load_value_i;
            rf_d    = (load_value_i == terminal);
            done_d  = 1'b0;
        end else if (halt_i) begin
            // state holds; term_pulse drops via the default
        end else if (tick && (rollover_value_i != '0)) begin
            // R == 0 lets the prescaler run but leaves the count and flags untouched
            count_d = stepped;
            rf_d    = arrive;
            tp_d    = arrive;
            done_d  = done_q | (arrive & (mode_i == MODE_ONESHOT));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            rf_q    <= 1'b0;
            tp_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            rf_q    <= rf_d;
            tp_q    <= tp_d;
            done_q  <= done_d;
        end
    end

    assign count_out_o     = count_q;
    assign rollover_flag_o = rf_q;
    assign term_pulse_o    = tp_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_flex_timer.sv
`timescale 1ns/1ps
module tb_flex_timer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       ce = 1'b0, halt = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] lv = '0;
    logic       up = 1'b1, mode = 1'b0;
    logic [3:0] rv = '0;
    logic [2:0] psv = '0;
    logic [3:0] count_out;
    logic       rollover_flag, term_pulse, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flex_timer #(
        .NUM_CNT_BITS  (4),
        .PRESCALE_BITS (3)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .count_enable_i   (ce),
        .halt_i           (halt),
        .clear_i          (clr),
        .load_i           (load),
        .load_value_i     (lv),
        .up_down_i        (up),
        .mode_i           (mode),
        .rollover_value_i (rv),
        .prescale_value_i (psv),
        .count_out_o      (count_out),
        .rollover_flag_o  (rollover_flag),
        .term_pulse_o     (term_pulse),
        .done_o           (done)
    );

    // Behavioural model: counts enabled cycles since the last tick and steps the
    // count with plain modular arithmetic.
    int m_count = 0;
    int m_since = 0;
    bit m_rf = 0, m_tp = 0, m_done = 0;

    always @(posedge clk or negedge n_rst) begin
        int per, term, nxt;
        bit en, tk;
        if (!n_rst) begin
            m_count <= 0; m_since <= 0; m_rf <= 0; m_tp <= 0; m_done <= 0;
        end else begin
            term = up ? int'(rv) : 0;
            per  = (psv <= 1) ? 1 : int'(psv);
            en   = ce && !halt && !m_done;
            tk   = en && (m_since + 1 >= per);
            if (up) nxt = (m_count == int'(rv)) ? 1 : (m_count + 1) % 16;
            else    nxt = (m_count == 0) ? int'(rv) - 1 : m_count - 1;
            if (clr) begin
                m_count <= 0; m_since <= 0; m_rf <= 0; m_tp <= 0; m_done <= 0;
            end else if (load) begin
                m_count <= int'(lv); m_since <= 0; m_done <= 0; m_tp <= 0;
                m_rf <= (int'(lv) == term);
            end else if (halt) begin
                m_tp <= 0;
            end else if (tk) begin
                m_since <= 0;
                if (rv == 0) begin
                    m_tp <= 0;
                end else begin
                    m_count <= nxt;
                    m_rf    <= (nxt == term);
                    m_tp    <= (nxt == term);
                    if (nxt == term && mode) m_done <= 1;
                end
            end else begin
                m_tp <= 0;
                if (en) m_since <= m_since + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            cmp("model_count", 32'(count_out), 32'(m_count));
            cmp("model_rollover_flag", 32'(rollover_flag), 32'(m_rf));
            cmp("model_term_pulse", 32'(term_pulse), 32'(m_tp));
            cmp("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int tp_cnt;

    initial begin
        step(3);
        n_rst = 1'b1;
        cmp("reset_count", 32'(count_out), 32'd0);
        cmp("reset_done", 32'(done), 32'd0);

        // Up, wrap, R=10, psv=4
        rv = 4'd10; psv = 3'd4; up = 1'b1; mode = 1'b0; ce = 1'b1;
        step(4);
        cmp("up_first_tick", 32'(count_out), 32'd1);
        step(36);
        cmp("up_reach_10", 32'(count_out), 32'd10);
        cmp("up_rf_at_10", 32'(rollover_flag), 32'd1);
        cmp("up_tp_at_10", 32'(term_pulse), 32'd1);
        tp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            tp_cnt += int'(term_pulse);
            if (i == 3) begin
                cmp("wrap_to_1", 32'(count_out), 32'd1);
                cmp("wrap_rf_low", 32'(rollover_flag), 32'd0);
            end
        end
        cmp("tp_per_40", 32'(tp_cnt), 32'd1);

        // Down, one-shot, load 5, psv=1
        ce = 1'b0; load = 1'b1; lv = 4'd5; up = 1'b0; mode = 1'b1; psv = 3'd1;
        step(1);
        cmp("load5", 32'(count_out), 32'd5);
        load = 1'b0; ce = 1'b1;
        step(1);
        cmp("down_4", 32'(count_out), 32'd4);
        step(4);
        cmp("down_0", 32'(count_out), 32'd0);
        cmp("oneshot_tp", 32'(term_pulse), 32'd1);
        cmp("oneshot_done", 32'(done), 32'd1);
        step(20);
        cmp("oneshot_hold_count", 32'(count_out), 32'd0);
        cmp("oneshot_hold_done", 32'(done), 32'd1);

        // Halt preserves prescaler phase
        clr = 1'b1; ce = 1'b0; up = 1'b1; mode = 1'b0; psv = 3'd4; rv = 4'd10;
        step(1);
        cmp("clear_done", 32'(done), 32'd0);
        clr = 1'b0; ce = 1'b1;
        step(2);
        halt = 1'b1;
        step(3);
        halt = 1'b0;
        step(1);
        cmp("halt_no_tick_6", 32'(count_out), 32'd0);
        step(1);
        cmp("halt_tick_7", 32'(count_out), 32'd1);

        // clear + load + tick together, then load while halted
        clr = 1'b1; load = 1'b1; lv = 4'd7; psv = 3'd1;
        step(1);
        cmp("clr_wins_count", 32'(count_out), 32'd0);
        cmp("clr_wins_rf", 32'(rollover_flag), 32'd0);
        clr = 1'b0; halt = 1'b1;
        step(1);
        cmp("load_halted", 32'(count_out), 32'd7);
        load = 1'b0;
        step(2);
        cmp("halted_hold", 32'(count_out), 32'd7);
        halt = 1'b0;

        // Up from above R: wraps through 15 -> 0
        ce = 1'b0; load = 1'b1; lv = 4'd12; up = 1'b1; rv = 4'd10; psv = 3'd1;
        step(1);
        cmp("load12", 32'(count_out), 32'd12);
        load = 1'b0; ce = 1'b1;
        step(3);
        cmp("above_15", 32'(count_out), 32'd15);
        step(1);
        cmp("above_wrap_0", 32'(count_out), 32'd0);
        step(1);
        cmp("above_1_rf", 32'(rollover_flag), 32'd0);
        step(9);
        cmp("above_10", 32'(count_out), 32'd10);
        cmp("above_rf_10", 32'(rollover_flag), 32'd1);
        rv = 4'd0;
        step(5);
        cmp("r0_frozen", 32'(count_out), 32'd10);
        cmp("r0_no_tp", 32'(term_pulse), 32'd0);

        // Asynchronous reset mid-count
        clr = 1'b1; ce = 1'b0; rv = 4'd10; psv = 3'd2;
        step(1);
        clr = 1'b0; ce = 1'b1;
        step(12);
        cmp("pre_reset_6", 32'(count_out), 32'd6);
        n_rst = 1'b0;
        #1;
        cmp("async_rst_count", 32'(count_out), 32'd0);
        cmp("async_rst_flags", 32'({rollover_flag, term_pulse, done}), 32'd0);
        #1;
        n_rst = 1'b1;
        step(1);
        cmp("post_rst_0", 32'(count_out), 32'd0);
        step(1);
        cmp("post_rst_1", 32'(count_out), 32'd1);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
